// File: rtl/regblk_pkg.sv
// rtl/regblk_pkg.sv - shared bus-request codes and FSM state type for the register block
package regblk_pkg;

    // Bus-request codes driven by the CPU core on busreq.
    localparam logic [3:0] BR_IDLE      = 4'b0000;
    localparam logic [3:0] BR_SEND_REG  = 4'b0001;
    localparam logic [3:0] BR_WRITE_REG = 4'b0010;
    localparam logic [3:0] BR_NEXT_OPND = 4'b0011;
    localparam logic [3:0] BR_CLEAR_ALL = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // True for every code that names an operation (IDLE is not a request).
    function automatic logic is_known(input logic [3:0] code);
        return (code == BR_SEND_REG)  || (code == BR_WRITE_REG) ||
               (code == BR_NEXT_OPND) || (code == BR_CLEAR_ALL);
    endfunction

endpackage

// File: rtl/regblk_file.sv
// rtl/regblk_file.sv - NREGS x DW register storage with one write port, one read port and indexed clear
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, zeroes every register
//   we       write enable for waddr/wdata
//   waddr    write index
//   wdata    write data
//   raddr    read index (combinational read)
//   rdata    register contents at raddr
//   clr_en   zero the register at clr_idx this cycle (wins over a write)
//   clr_idx  index to zero
module regblk_file
    import regblk_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 8,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic          clr_en,
    input  logic [IW-1:0] clr_idx
);

    logic [DW-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_idx] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/regblk_bus_responder.sv
// rtl/regblk_bus_responder.sv - services CPU bus-request codes against a small register file
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   busreq   request code from the CPU core; a change to a non-zero code is a request
//   opnd     register number from the instruction stream (used by NEXT_OPND)
//   wb_data  ALU result written by WRITE_REG
//   rd_data  register value loaded by SEND_REG, held until the next SEND_REG
//   ack      one-cycle pulse when a request completes
//   busy     high while an operation is in progress (EXEC or CLEAR)
//   err      one-cycle pulse for an unknown code or a request dropped while busy
module regblk_bus_responder
    import regblk_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    busreq,
    input  logic [3:0]    opnd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] rd_data,
    output logic          ack,
    output logic          busy,
    output logic          err
);

    localparam int IW = $clog2(NREGS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

    state_t        state, state_d;
    logic [3:0]    busreq_q;
    logic [3:0]    code_q;
    logic [3:0]    opnd_q;
    logic [DW-1:0] wb_q;
    logic [IW-1:0] sel;
    logic [IW-1:0] sel_cap;
    logic [IW-1:0] clr_cnt;
    logic          err_pend;

    logic          detect;
    logic          capture;
    logic          apply;
    logic          clr_en;
    logic          ack_d;
    logic          err_d;
    logic          pend_d;
    logic          drop;
    logic          unknown;
    logic [DW-1:0] rd_word;

    // A request is a change of busreq to any non-zero code; holding a code
    // therefore services it only once.
    assign detect = (busreq != busreq_q) && (busreq != BR_IDLE);
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        capture = 1'b0;
        apply   = 1'b0;
        clr_en  = 1'b0;
        ack_d   = 1'b0;
        drop    = 1'b0;
        unknown = 1'b0;
        case (state)
            ST_IDLE: begin
                if (detect) begin
                    if (busreq == BR_CLEAR_ALL) begin
                        state_d = ST_CLEAR;
                    end else if (is_known(busreq)) begin
                        state_d = ST_EXEC;
                        capture = 1'b1;
                    end else begin
                        unknown = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                apply   = 1'b1;
                ack_d   = 1'b1;
                drop    = detect;
            end
            ST_CLEAR: begin
                clr_en = 1'b1;
                drop   = detect;
                if (clr_cnt == LAST_IDX) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A drop on the same edge that completes an operation would put ack
        // and err high together; its err is deferred by one cycle instead.
        // The FSM is always back in IDLE then, so no ack can collide with it.
        pend_d = drop & ack_d;
        err_d  = (unknown | drop | err_pend) & ~ack_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busreq_q <= BR_IDLE;
            code_q   <= BR_IDLE;
            opnd_q   <= '0;
            wb_q     <= '0;
            sel      <= '0;
            sel_cap  <= '0;
            clr_cnt  <= '0;
            rd_data  <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            busreq_q <= busreq;
            ack      <= ack_d;
            err      <= err_d;
            err_pend <= pend_d;
            if (capture) begin
                code_q  <= busreq;
                sel_cap <= sel;
                if (busreq == BR_NEXT_OPND) begin
                    opnd_q <= opnd;
                end
                if (busreq == BR_WRITE_REG) begin
                    wb_q <= wb_data;
                end
            end
            if (apply && (code_q == BR_NEXT_OPND)) begin
                sel <= opnd_q[IW-1:0];
            end
            if (apply && (code_q == BR_SEND_REG)) begin
                rd_data <= rd_word;
            end
            if (clr_en) begin
                clr_cnt <= (clr_cnt == LAST_IDX) ? '0 : clr_cnt + 1'b1;
            end
        end
    end

    regblk_file #(
        .NREGS (NREGS),
        .DW    (DW),
        .IW    (IW)
    ) u_file (
        .clk     (clk),
        .rst     (rst),
        .we      (apply && (code_q == BR_WRITE_REG)),
        .waddr   (sel_cap),
        .wdata   (wb_q),
        .raddr   (sel_cap),
        .rdata   (rd_word),
        .clr_en  (clr_en),
        .clr_idx (clr_cnt)
    );

endmodule

// File: doc/regblk_bus_responder.md
REGBLK_BUS_RESPONDER -- requirements
Module: regblk_bus_responder

Interface
REQ-001 The block SHALL have one parameter: NREGS, default 16, number of registers (power of two, 2..16).
REQ-002 The block SHALL have one parameter: DW, default 8, register and data width in bits.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 busreq  input  4  bus-request code driven by the CPU core on uo_out[3:0].
REQ-006 opnd  input  4  register number taken from the instruction stream (ui_in[7:4]).
REQ-007 wb_data  input  DW  ALU result to be written back.
REQ-008 rd_data  output  DW  register value presented to the CPU on uio_in.
REQ-009 ack  output  1  one-cycle pulse: request serviced.
REQ-010 busy  output  1  high while the block cannot accept a request.
REQ-011 err  output  1  one-cycle pulse: unknown or dropped request.

Function
REQ-012 Codes SHALL be: 0000 IDLE, 0001 SEND_REG, 0010 WRITE_REG, 0011 NEXT_OPND, 0100 CLEAR_ALL; all others unknown.
REQ-013 The block SHALL register busreq each cycle as busreq_q; a request SHALL be detected when busreq != busreq_q and busreq != 0000.
REQ-014 A held code SHALL be serviced once only; re-servicing the same code requires a change of busreq, either to 0000 or to another code.
REQ-015 FSM states SHALL be IDLE, EXEC, CLEAR; IDLE->EXEC on a detected known request other than CLEAR_ALL; IDLE->CLEAR on CLEAR_ALL; EXEC->IDLE unconditionally.
REQ-016 The edge entering EXEC SHALL capture the code, plus opnd (NEXT_OPND) or wb_data (WRITE_REG).
REQ-017 The edge leaving EXEC SHALL apply the action and raise ack for exactly the following cycle.
REQ-018 NEXT_OPND SHALL load sel <= opnd[log2(NREGS)-1:0].
REQ-019 SEND_REG SHALL load rd_data <= regs[sel]; rd_data SHALL hold until the next SEND_REG or reset.
REQ-020 WRITE_REG SHALL load regs[sel] <= captured wb_data.
REQ-021 SEND_REG and WRITE_REG SHALL use the sel value in effect when the request is captured.
REQ-022 CLEAR SHALL zero one register per cycle, from index 0 to NREGS-1, using a counter.
REQ-023 On the cycle after the last register is cleared, CLEAR SHALL return to IDLE and pulse ack; sel and rd_data SHALL be unchanged by CLEAR.
REQ-024 busy SHALL be 1 in EXEC and CLEAR, and 0 in IDLE.
REQ-025 A request detected while busy SHALL be dropped with an err pulse; it SHALL NOT be queued.
REQ-026 An unknown code detected in IDLE SHALL pulse err, leave the FSM in IDLE and leave all state unchanged.
REQ-027 ack and err SHALL never both be high in the same cycle.
REQ-028 Request-to-ack latency SHALL be 2 cycles for SEND_REG, WRITE_REG and NEXT_OPND, and NREGS+1 cycles for CLEAR_ALL.

Reset
REQ-029 While rst=1, the block SHALL set: all regs=0, sel=0, rd_data=0, busreq_q=0000, FSM=IDLE, clear counter=0, ack=0, err=0, busy=0.
REQ-030 rst asserted mid-EXEC or mid-CLEAR SHALL abort the operation with no ack.
REQ-031 A busreq held non-zero across reset release SHALL be detected as a new request in the first cycle after release.

Structure
REQ-032 Package regblk_pkg SHALL hold the busreq code localparams and the FSM state enum; the CPU core SHALL import the same codes.
REQ-033 Storage SHALL be a sub-module regblk_file: NREGS x DW, one synchronous write port, one combinational read port, synchronous clear by index.
REQ-034 The FSM, change detection and the sel register SHALL live in regblk_bus_responder.

Verification
REQ-035 Scenario: after reset, busreq 0001 -> ack at cycle +2, rd_data=0x00, err=0.
REQ-036 Scenario: opnd=1, busreq 0011; then wb_data=0x04, busreq 0010; then busreq 0001 -> rd_data=0x04, and each request acks exactly once.
REQ-037 Scenario: busreq 0001 held 10 cycles -> exactly one ack; toggle to 0000 and back to 0001 -> a second ack.
REQ-038 Scenario: regs 3 and 15 loaded 0xA5, then busreq 0100 -> busy for 16 cycles, ack at +17, reads of regs 3 and 15 return 0x00.
REQ-039 Scenario: busreq 0001 changed to 0011 in the cycle after detection -> err pulse and sel unchanged; busreq 0111 in IDLE -> err pulse and no ack.
REQ-040 Scenario: rst asserted mid-CLEAR -> no ack, all outputs at reset values the next cycle.
